// File: rtl/top_uart_tx.sv
// UART transmitter with a first-word-fall-through TX FIFO.
// Frame: one start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1).
// Every bit lasts a baud divisor latched at frame start; divisors below 2 run as 2.
module top_uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                    clk_i_top_tx,
  input  logic                    rst_i_top_tx,
  input  logic                    active_i_top_tx,
  input  logic                    wr_en_i_top_tx,
  input  logic [DATA_WIDTH-1:0]   data_i_top_tx,
  input  logic [DATA_WIDTH*2:0]   baud_div_top_tx,
  output logic                    data_o_serial_top_tx,
  output logic                    full_o_top_tx,
  output logic                    empty_o_top_tx,
  output logic                    busy_o_top_tx,
  output logic                    done_o_top_tx
);

  localparam int unsigned ADDR_WIDTH_FIFO = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W           = ADDR_WIDTH_FIFO + 1;
  localparam int unsigned BAUD_W          = DATA_WIDTH * 2 + 1;
  localparam int unsigned BIT_W           = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [ADDR_WIDTH_FIFO-1:0] wr_ptr;
  logic [ADDR_WIDTH_FIFO-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;

  // Transmit datapath
  state_t                     state;
  logic [DATA_WIDTH-1:0]      shift;
  logic [BAUD_W-1:0]          baud_lat;
  logic [BAUD_W-1:0]          baud_cnt;
  logic [BIT_W-1:0]           bit_cnt;

  // Combinational helpers
  logic                       pop_c;
  logic                       wr_acc_c;
  logic [CNT_W-1:0]           count_nxt_c;
  logic [DATA_WIDTH-1:0]      head_c;
  logic [BAUD_W-1:0]          baud_eff_c;
  logic                       baud_end_c;
  logic                       last_bit_c;

  // A pop happens only from IDLE, when enabled and the registered empty flag is clear.
  assign pop_c       = (state == IDLE) && active_i_top_tx && !empty_o_top_tx;

  // A write while full still lands if the same edge frees a slot.
  assign wr_acc_c    = wr_en_i_top_tx && (!full_o_top_tx || pop_c);

  assign count_nxt_c = count + CNT_W'(wr_acc_c) - CNT_W'(pop_c);

  // Head of queue is visible without a read strobe.
  assign head_c      = mem[rd_ptr];

  // Divisors of 0 and 1 cannot produce a sensible bit time, so run them as 2.
  assign baud_eff_c  = (baud_div_top_tx < BAUD_W'(2)) ? BAUD_W'(2) : baud_div_top_tx;

  assign baud_end_c  = (baud_cnt == (baud_lat - BAUD_W'(1)));
  assign last_bit_c  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  // FIFO storage write port; contents are don't-care after reset.
  always_ff @(posedge clk_i_top_tx) begin
    if (!rst_i_top_tx && wr_acc_c) begin
      mem[wr_ptr] <= data_i_top_tx;
    end
  end

  // FIFO pointers, occupancy count and registered full/empty flags.
  always_ff @(posedge clk_i_top_tx) begin
    if (rst_i_top_tx) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      full_o_top_tx  <= 1'b0;
      empty_o_top_tx <= 1'b1;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH_FIFO'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH_FIFO'(1);
      end
      count          <= count_nxt_c;
      full_o_top_tx  <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
      empty_o_top_tx <= (count_nxt_c == '0);
    end
  end

  // Frame sequencer: start, data bits, stop, each held for the latched bit time.
  always_ff @(posedge clk_i_top_tx) begin
    if (rst_i_top_tx) begin
      state                <= IDLE;
      shift                <= '0;
      baud_lat             <= BAUD_W'(2);
      baud_cnt             <= '0;
      bit_cnt              <= '0;
      data_o_serial_top_tx <= 1'b1;
      busy_o_top_tx        <= 1'b0;
      done_o_top_tx        <= 1'b0;
    end else begin
      done_o_top_tx <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_c) begin
            shift                <= head_c;
            baud_lat             <= baud_eff_c;
            baud_cnt             <= '0;
            bit_cnt              <= '0;
            data_o_serial_top_tx <= 1'b0;
            busy_o_top_tx        <= 1'b1;
            state                <= START;
          end
        end

        START: begin
          if (baud_end_c) begin
            baud_cnt             <= '0;
            bit_cnt              <= '0;
            data_o_serial_top_tx <= shift[0];
            shift                <= shift >> 1;
            state                <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_end_c) begin
            baud_cnt <= '0;
            if (last_bit_c) begin
              data_o_serial_top_tx <= 1'b1;
              state                <= STOP;
            end else begin
              bit_cnt              <= bit_cnt + BIT_W'(1);
              data_o_serial_top_tx <= shift[0];
              shift                <= shift >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_end_c) begin
            baud_cnt      <= '0;
            done_o_top_tx <= 1'b1;
            busy_o_top_tx <= 1'b0;
            state         <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state                <= IDLE;
          data_o_serial_top_tx <= 1'b1;
          busy_o_top_tx        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_uart_tx.sv
// Bench for top_uart_tx: waveform and UART-receiver based checks against a queue model.
module tb_top_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        active = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [16:0] baud = 17'd16;
  logic        line, full, empty, busy, done;

  int          cyc = 0;
  int          done_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];

  top_uart_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) dut (
    .clk_i_top_tx         (clk),
    .rst_i_top_tx         (rst),
    .active_i_top_tx      (active),
    .wr_en_i_top_tx       (wr_en),
    .data_i_top_tx        (data),
    .baud_div_top_tx      (baud),
    .data_o_serial_top_tx (line),
    .full_o_top_tx        (full),
    .empty_o_top_tx       (empty),
    .busy_o_top_tx        (busy),
    .done_o_top_tx        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Ideal line level t cycles into a frame of byte b with the given bit time.
  function automatic logic exp_line(input logic [7:0] b, input int t, input int bt);
    int idx;
    idx = t / bt;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; active = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Reference receiver: finds a start edge, samples mid-bit, returns at the stop bit's last cycle.
  task automatic rx_frame(input int bt, input int limit, output logic [7:0] b,
                          output int start_cyc, output bit ok);
    int   n, off;
    logic s0, s9;
    bit   found;
    found = 0; b = 8'h00; ok = 0; start_cyc = -1; n = 0; s0 = 1'b1; s9 = 1'b0;
    while (!found && n < limit) begin
      @(negedge clk);
      n++;
      if (line === 1'b0) found = 1;
    end
    if (!found) return;
    start_cyc = cyc;
    off = 0;
    for (int i = 0; i < 10; i++) begin
      repeat (i * bt + bt / 2 - off) @(negedge clk);
      off = i * bt + bt / 2;
      if (i == 0) s0 = line;
      else if (i == 9) s9 = line;
      else b[i-1] = line;
    end
    repeat (10 * bt - 1 - off) @(negedge clk);
    ok = (s0 === 1'b0) && (s9 === 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (line !== 1'b1) begin bad++; $display("FAIL reset_line got=%b want=1", line); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_single();
    int mism, bmism, d0;
    do_reset();
    baud = 17'd868; active = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    total++; if (empty !== 1'b0 || line !== 1'b1) begin bad++;
      $display("FAIL single_after_write empty=%b line=%b want empty=0 line=1", empty, line); end
    @(negedge clk);
    d0 = done_cnt; mism = 0; bmism = 0;
    for (int t = 0; t < 8680; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 100) baud = 17'd5;
      if (line !== exp_line(8'hA5, t, 868)) mism++;
      if (busy !== 1'b1) bmism++;
    end
    total++; if (mism != 0) begin bad++; $display("FAIL single_wave bad_cycles=%0d want=0", mism); end
    total++; if (bmism != 0) begin bad++; $display("FAIL single_busy bad_cycles=%0d want=0", bmism); end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0 || line !== 1'b1) begin bad++;
      $display("FAIL single_end done=%b busy=%b line=%b want 1/0/1", done, busy, line); end
    @(negedge clk);
    total++; if (done !== 1'b0 || done_cnt - d0 != 1) begin bad++;
      $display("FAIL single_done_pulse done=%b pulses=%0d want 0/1", done, done_cnt - d0); end
    baud = 17'd16;
  endtask

  task automatic test_fill();
    logic [7:0] b, got;
    int st;
    bit ok;
    do_reset();
    baud = 17'd16; active = 1'b0; exp_q.delete();
    for (int i = 0; i < 33; i++) begin
      b = 8'($urandom_range(0, 255));
      write_byte(b);
      if (i < 32) exp_q.push_back(b);
      if (i == 30) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full31 got=%b want=0", full); end
      end
      if (i == 31) begin
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full32 got=%b want=1", full); end
      end
      if (i == 32) begin
        total++; if (full !== 1'b1 || line !== 1'b1) begin bad++;
          $display("FAIL fill_drop full=%b line=%b want 1/1", full, line); end
      end
    end
    active = 1'b1;
    for (int k = 0; k < 32; k++) begin
      rx_frame(16, 400, got, st, ok);
      b = exp_q.pop_front();
      total++; if (!ok || got !== b) begin bad++;
        $display("FAIL fill_byte%0d got=%h ok=%0d want=%h", k, got, ok, b); end
    end
    rx_frame(16, 500, got, st, ok);
    total++; if (st != -1) begin bad++; $display("FAIL fill_extra_frame got=%h want none", got); end
    total++; if (empty !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL fill_end empty=%b busy=%b want 1/0", empty, busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic [7:0] pat [3];
    int st [3];
    bit ok;
    do_reset();
    baud = 17'd16; active = 1'b0;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    for (int i = 0; i < 3; i++) write_byte(pat[i]);
    active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_frame(16, 400, got, st[i], ok);
      total++; if (!ok || got !== pat[i]) begin bad++;
        $display("FAIL b2b_byte%0d got=%h ok=%0d want=%h", i, got, ok, pat[i]); end
    end
    total++; if (st[1] - st[0] != 161) begin bad++;
      $display("FAIL b2b_gap01 got=%0d want=161", st[1] - st[0]); end
    total++; if (st[2] - st[1] != 161) begin bad++;
      $display("FAIL b2b_gap12 got=%0d want=161", st[2] - st[1]); end
  endtask

  task automatic test_full_simul();
    logic [7:0] b, got;
    int st, bt;
    bit ok;
    do_reset();
    bt = int'($urandom_range(3, 10));
    baud = 17'(bt); active = 1'b0; exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom_range(0, 255));
      write_byte(b);
      exp_q.push_back(b);
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL simul_prefull got=%b want=1", full); end
    @(negedge clk);
    active = 1'b1; wr_en = 1'b1; data = 8'h3C;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL simul_full_held got=%b want=1", full); end
    for (int k = 0; k < 33; k++) begin
      rx_frame(bt, 20 * bt + 10, got, st, ok);
      b = exp_q.pop_front();
      total++; if (!ok || got !== b) begin bad++;
        $display("FAIL simul_byte%0d got=%h ok=%0d want=%h", k, got, ok, b); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL simul_end_empty got=%b want=1", empty); end
  endtask

  task automatic test_reset_mid();
    int n, mism, d0;
    bit found;
    do_reset();
    baud = 17'd16; active = 1'b0;
    write_byte(8'h81);
    for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
    active = 1'b1;
    found = 0; n = 0;
    while (!found && n < 50) begin
      @(negedge clk);
      n++;
      if (line === 1'b0) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL rmid_start got=none want=start bit"); end
    repeat (4 * 16 + 8) @(negedge clk);
    total++; if (line !== exp_line(8'h81, 72, 16)) begin bad++;
      $display("FAIL rmid_bit3 got=%b want=%b", line, exp_line(8'h81, 72, 16)); end
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (line !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin bad++;
      $display("FAIL rmid_after line=%b empty=%b busy=%b full=%b want 1/1/0/0", line, empty, busy, full); end
    mism = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (line !== 1'b1) mism++;
    end
    total++; if (mism != 0 || done_cnt != d0) begin bad++;
      $display("FAIL rmid_quiet low_cycles=%0d dones=%0d want 0/0", mism, done_cnt - d0); end
  endtask

  task automatic test_clamp_disable();
    logic [7:0] b1, b2, got;
    int mism, idle_bad, st;
    bit ok;
    do_reset();
    baud = 17'd1; active = 1'b0;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    write_byte(b1);
    write_byte(b2);
    @(negedge clk);
    active = 1'b1;
    @(negedge clk);
    active = 1'b0;
    mism = 0;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) @(negedge clk);
      if (line !== exp_line(b1, t, 2)) mism++;
    end
    total++; if (mism != 0) begin bad++; $display("FAIL clamp_wave bad_cycles=%0d want=0", mism); end
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL clamp_done done=%b busy=%b want 1/0", done, busy); end
    idle_bad = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (line !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    total++; if (idle_bad != 0 || empty !== 1'b0) begin bad++;
      $display("FAIL clamp_hold bad_cycles=%0d empty=%b want 0/0", idle_bad, empty); end
    active = 1'b1;
    rx_frame(2, 10, got, st, ok);
    total++; if (!ok || got !== b2) begin bad++;
      $display("FAIL clamp_second got=%h ok=%0d want=%h", got, ok, b2); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL clamp_empty got=%b want=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_full_simul();
    test_reset_mid();
    test_clamp_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
